mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: MUL_CYCLES, default 1, number of COMPUTE cycles allowed for the combinational signed 8x8 product to settle; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  8 each  requester 0 signed two's-complement operands.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same widths and meanings for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_id  output  1  requester index owning the result.
REQ-010 rsp_m  output  16  signed two's-complement product.
REQ-011 rsp_ready  input  1  consumer takes the result this cycle.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL share one signed 8x8 -> 16 multiplier datapath between two requesters; FSM states IDLE, COMPUTE, RESPOND.
REQ-014 In IDLE, the block SHALL assert at most one reqN_ready, combinationally, to the granted requester only; the other ready is 0.
REQ-015 Grant SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not equal to last_grant.
REQ-016 On valid&&ready in IDLE, the block SHALL capture a, b and id into internal registers, load the counter with MUL_CYCLES and enter COMPUTE.
REQ-017 Operands SHALL NOT need to be held stable by the requester after the accepting edge.
REQ-018 In COMPUTE, the counter SHALL decrement each cycle; on the cycle it equals 1 the block SHALL register the product into rsp_m, id into rsp_id, and enter RESPOND.
REQ-019 Latency: for acceptance in cycle k, rsp_valid SHALL first be high in cycle k+MUL_CYCLES+1.
REQ-020 In RESPOND, rsp_valid SHALL be 1 and rsp_m/rsp_id SHALL remain stable until rsp_valid&&rsp_ready; on that edge go IDLE, rsp_valid 0, last_grant <= rsp_id.
REQ-021 Both reqN_ready SHALL be 0 in COMPUTE and RESPOND; no acceptance in the cycle a response is taken; peak throughput one op per MUL_CYCLES+2 cycles.
REQ-022 A reqN_valid dropped before grant SHALL have no effect; no state change in IDLE without a valid.
REQ-023 Product SHALL be exact signed: rsp_m = sign-correct a*b over full range, including -128*-128 = 16'h4000 and -128*127 = 16'hC080.
REQ-024 rsp_m SHALL hold its last value while not in RESPOND (no glitching to the datapath output).

Reset
REQ-025 When rst_n is low at a rising edge: state IDLE, rsp_valid 0, rsp_m 16'h0000, rsp_id 0, last_grant 1, counter 0.
REQ-026 Both reqN_ready SHALL be 0 during any cycle with rst_n low.
REQ-027 Reset in COMPUTE or RESPOND SHALL abandon the operation; no response for it is ever produced.
REQ-028 After reset, the first tie SHALL be granted to requester 0.

Verification
REQ-029 Single op: req0 a=8'hFD(-3), b=8'h05, MUL_CYCLES=1, rsp_ready=1 -> req0_ready in accept cycle k, rsp_valid in k+2, rsp_m=16'hFFF1, rsp_id=0, busy low in k+3.
REQ-030 Tie and fairness: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; req0 (2,3)->16'h0006, req1 (-128,-128)->16'h4000.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESPOND -> rsp_valid, rsp_m, rsp_id stable; both ready 0; completion on first rsp_ready=1.
REQ-032 Latency sweep: MUL_CYCLES=1,4,15 with a=127,b=-128 -> rsp_m=16'hC080 first valid at k+2, k+5, k+16.
REQ-033 Mid-op reset: rst_n low one cycle during COMPUTE -> rsp_valid never asserted for that op, next tie granted to req0, outputs at reset values.
REQ-034 Operand change after accept: req1 accepted with (7,-7) then inputs changed to (1,1) -> rsp_m=16'hFFCF.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-requester arbiter sharing one signed 8x8 -> 16 multiplier.
// Round-robin grant in IDLE, a MUL_CYCLES settle window in COMPUTE, and a held
// result in RESPOND until the consumer takes it.
module mul_arbiter #(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_m,
    input  logic        rsp_ready,

    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StRespond
    } state_e;

    localparam logic [3:0] CntLoad = 4'(MUL_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        id_q;
    logic        last_grant_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [15:0] rsp_m_q;

    logic        grant;
    logic        accept_en;
    logic        accept;
    logic signed [15:0] prod;

    // Shared datapath; operands come from the capture registers, so the
    // requester may change its inputs right after the accepting edge.
    assign prod = $signed(a_q) * $signed(b_q);

    // Round-robin pick: on a tie the requester that did not finish last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        // Gated by rst_n so neither ready can rise during a reset cycle.
        accept_en  = rst_n && (state_q == StIdle);
        req0_ready = accept_en && req0_valid && !grant;
        req1_ready = accept_en && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    // Single FSM: capture, count down, register the product, hold for the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_m_q      <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= grant ? req1_a : req0_a;
                        b_q     <= grant ? req1_b : req0_b;
                        id_q    <= grant;
                        cnt_q   <= CntLoad;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    if (cnt_q == 4'd1) begin
                        rsp_m_q     <= prod;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= 4'd0;
                        state_q     <= StRespond;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRespond: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= rsp_id_q;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_m     = rsp_m_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: stimulus pushes expected results, a monitor
// pops and compares each response the DUT hands over.
module tb_mul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [15:0] rsp_m;

    // Sweep instances share one stimulus set.
    logic        s_v;
    logic [7:0]  s_a, s_b;
    logic        s_zero_v;
    logic [7:0]  s_zero;
    logic        s_rr;
    logic        s4_r0, s4_r1, s4_rv, s4_id, s4_busy;
    logic        s15_r0, s15_r1, s15_rv, s15_id, s15_busy;
    logic [15:0] s4_m, s15_m;

    mul_arbiter #(.MUL_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_m(rsp_m), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    mul_arbiter #(.MUL_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_v), .req0_a(s_a), .req0_b(s_b), .req0_ready(s4_r0),
        .req1_valid(s_zero_v), .req1_a(s_zero), .req1_b(s_zero), .req1_ready(s4_r1),
        .rsp_valid(s4_rv), .rsp_id(s4_id), .rsp_m(s4_m), .rsp_ready(s_rr),
        .busy(s4_busy)
    );

    mul_arbiter #(.MUL_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_v), .req0_a(s_a), .req0_b(s_b), .req0_ready(s15_r0),
        .req1_valid(s_zero_v), .req1_a(s_zero), .req1_b(s_zero), .req1_ready(s15_r1),
        .rsp_valid(s15_rv), .rsp_id(s15_id), .rsp_m(s15_m), .rsp_ready(s_rr),
        .busy(s15_busy)
    );

    typedef struct packed {
        logic        id;
        logic [15:0] m;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [15:0] m);
        exp_t e;
        e.id = id;
        e.m  = m;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic gid, output int k);
        logic ok;
        ok  = 1'b0;
        gid = 1'b0;
        k   = -1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                k   = cyc;
                ok  = 1'b1;
            end
        end
        check("grant within bound", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output int k);
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) k = cyc;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare each handed-over response against the scoreboard head.
    always @(negedge clk) begin
        check("ready exclusive", 32'(req0_ready & req1_ready), 32'd0);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp with empty scoreboard", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_m", 32'(rsp_m), 32'(mon_e.m));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gid;
        int   k, k2, l4, l15;
        logic [15:0] m4, m15;

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b1;
        s_v = 1'b1; s_a = 8'h00; s_b = 8'h00;
        s_zero_v = 1'b0; s_zero = 8'h00; s_rr = 1'b1;

        // Readies must stay low while in reset even with valids high.
        @(negedge clk);
        check("reset req0_ready", 32'(req0_ready), 32'd0);
        check("reset req1_ready", 32'(req1_ready), 32'd0);
        check("reset sweep ready", 32'(s4_r0), 32'd0);
        tick();
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; s_v = 1'b0;
        @(negedge clk);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_m", 32'(rsp_m), 32'h0000);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Single op: -3 * 5.
        tick();
        req0_valid = 1'b1; req0_a = 8'hFD; req0_b = 8'h05;
        wait_grant(gid, k);
        check("t1 grant id", 32'(gid), 32'd0);
        push_exp(1'b0, 16'hFFF1);
        tick();
        req0_valid = 1'b0; req0_a = 8'h00;
        @(negedge clk);
        check("t1 busy k+1", 32'(busy), 32'd1);
        check("t1 rsp_valid k+1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1 rsp_valid k+2", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("t1 busy k+3", 32'(busy), 32'd0);

        // Tie and fairness after a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03;
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80;
        for (int n = 0; n < 4; n++) begin
            wait_grant(gid, k);
            check("t2 alternating grant", 32'(gid), 32'(n % 2));
            push_exp(gid, gid ? 16'h4000 : 16'h0006);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t2 drained");

        // Backpressure, with requester 1 changing operands after acceptance.
        tick();
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'hF9;
        wait_grant(gid, k);
        check("t3 grant id", 32'(gid), 32'd1);
        push_exp(1'b1, 16'hFFCF);
        tick();
        req1_valid = 1'b0; req1_a = 8'h01; req1_b = 8'h01;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
        wait_rsp(k2);
        check("t3 latency", 32'(k2 - k), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("t3 hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("t3 hold rsp_m", 32'(rsp_m), 32'hFFCF);
            check("t3 hold rsp_id", 32'(rsp_id), 32'd1);
            check("t3 hold req0_ready", 32'(req0_ready), 32'd0);
            check("t3 hold req1_ready", 32'(req1_ready), 32'd0);
            if (i < 4) @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        check("t3 no accept on take", 32'(req0_ready), 32'd0);
        @(negedge clk);
        check("t3 idle after take", 32'(busy), 32'd0);
        drain("t3 drained");

        // Complete a req0 op so last_grant is 0, then abort a req1 op with reset.
        tick();
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h05;
        wait_grant(gid, k);
        push_exp(gid, 16'h0019);
        tick();
        req0_valid = 1'b0;
        drain("t4 pre-op drained");
        tick();
        req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h05;
        wait_grant(gid, k);
        check("t4 abort op grant", 32'(gid), 32'd1);
        tick();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("t4 reset req0_ready", 32'(req0_ready), 32'd0);
        check("t4 reset req1_ready", 32'(req1_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t4 rsp_valid after abort", 32'(rsp_valid), 32'd0);
        check("t4 rsp_m reset", 32'(rsp_m), 32'h0000);
        check("t4 rsp_id reset", 32'(rsp_id), 32'd0);
        check("t4 busy reset", 32'(busy), 32'd0);
        check("t4 tie to req0", 32'(req0_ready), 32'd1);
        check("t4 tie not req1", 32'(req1_ready), 32'd0);
        push_exp(1'b0, 16'h0019);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("t4 drained");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4 no stray rsp", 32'(rsp_valid), 32'd0);
        end

        // Latency sweep: 127 * -128 on MUL_CYCLES 1, 4 and 15.
        tick();
        req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h80;
        wait_grant(gid, k);
        push_exp(1'b0, 16'hC080);
        tick();
        req0_valid = 1'b0;
        wait_rsp(k2);
        check("sweep1 latency", 32'(k2 - k), 32'd2);
        drain("sweep1 drained");

        tick();
        s_v = 1'b1; s_a = 8'h7F; s_b = 8'h80;
        @(negedge clk);
        check("sweep4 ready", 32'(s4_r0), 32'd1);
        check("sweep15 ready", 32'(s15_r0), 32'd1);
        k = cyc;
        tick();
        s_v = 1'b0; s_a = 8'h00; s_b = 8'h00;
        l4 = -1; l15 = -1; m4 = 16'h0; m15 = 16'h0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (s4_rv && l4 < 0) begin l4 = cyc - k; m4 = s4_m; end
            if (s15_rv && l15 < 0) begin l15 = cyc - k; m15 = s15_m; end
        end
        check("sweep4 latency", 32'(l4), 32'd5);
        check("sweep4 product", 32'(m4), 32'hC080);
        check("sweep15 latency", 32'(l15), 32'd16);
        check("sweep15 product", 32'(m15), 32'hC080);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
